// File: rtl/intersect_scheduler.sv
// Ray/triangle intersect scheduler: issues triangle indices for one ray,
// tracks in-flight tags and reduces returning hits to the nearest one.
module intersect_scheduler #(
  parameter int PIPE_LAT = 3,
  parameter int IDX_W    = 10,
  parameter int T_W      = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ray_valid,
  output logic             ray_ready,
  input  logic [IDX_W-1:0] tri_count,
  output logic             tri_issue,
  output logic [IDX_W-1:0] tri_idx,
  input  logic             hit_flag,
  input  logic [T_W-1:0]   hit_t,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_hit,
  output logic [T_W-1:0]   res_t,
  output logic [IDX_W-1:0] res_idx
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam logic [PIPE_LAT-1:0] LAST =
    (PIPE_LAT)'(1) << (PIPE_LAT - 1);

  state_t           state;
  state_t           nxt;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] count;
  logic [PIPE_LAT-1:0] tv;
  logic [IDX_W-1:0] tidx [PIPE_LAT];
  logic             accept;
  logic             ret;
  logic             pending;
  logic             better;

  assign ray_ready = (state == IDLE);
  assign accept    = ray_valid && ray_ready;
  assign tri_issue = (state == ISSUE);
  assign tri_idx   = tri_issue ? cnt : '0;
  assign res_valid = (state == DONE);

  assign ret     = tv[PIPE_LAT-1];
  // Anything still in flight ahead of the final stage keeps us draining
  assign pending = |(tv & ~LAST);
  assign better  = ret && hit_flag && (hit_t < res_t);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          nxt = (tri_count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (cnt == count - IDX_W'(1)) begin
          nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!pending) begin
          nxt = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      count   <= '0;
      res_hit <= 1'b0;
      res_t   <= '1;
      res_idx <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        count   <= tri_count;
        cnt     <= '0;
        res_hit <= 1'b0;
        res_t   <= '1;
        res_idx <= '0;
      end else begin
        if (tri_issue) begin
          cnt <= cnt + IDX_W'(1);
        end
        if (better) begin
          res_hit <= 1'b1;
          res_t   <= hit_t;
          res_idx <= tidx[PIPE_LAT-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tv <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        tidx[i] <= '0;
      end
    end else begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        tv[i]   <= tv[i-1];
        tidx[i] <= tidx[i-1];
      end
      tv[0]   <= tri_issue;
      tidx[0] <= tri_idx;
    end
  end

endmodule
